// File: rtl/spi_link_pkg.sv
// Shared SPI link definitions: word width, SPI mode and receiver FSM states.
package spi_link_pkg;
   localparam int SPI_DATA_W = 16;
   localparam int SPI_MODE   = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;
endpackage

// File: rtl/spi_frame_receiver_sync_ff.sv
// Single-bit multi-stage synchronizer with a selectable reset (idle) level.
module sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   // Shift the asynchronous input one stage deeper each clock.
   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   // Chain flops, preset to the idle level of the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= {STAGES{RST_VAL}};
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];
endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 receive endpoint: oversampled SPI lines, MSB-first word assembly,
// valid/ready output with overrun and short-frame pulses.
module spi_frame_receiver
   import spi_link_pkg::*;
#(
   parameter int DATA_W      = SPI_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_clock,
   input  logic              spi_data,
   input  logic              cs_n,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              overrun,
   output logic              frame_err,
   output logic              busy
);
   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic sclk_s, data_s, csn_s;

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi_clock), .q(sclk_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (.clk(clk), .rst_n(rst_n), .d(spi_data),  .q(data_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn  (.clk(clk), .rst_n(rst_n), .d(cs_n),      .q(csn_s));

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              m_valid_q, m_valid_d;
   logic              overrun_q, overrun_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;
   logic              sclk_prev_q, sclk_prev_d, csn_prev_q, csn_prev_d;
   logic              sclk_rise_q, sclk_rise_d, cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
   logic              data_q, data_d, csn_q, csn_d;
   logic              word_done_s;
   logic [DATA_W-1:0] word_s;

   // Edge detect, FSM, shift register and output handshake next-state logic.
   always_comb begin
      sclk_prev_d = sclk_s;
      csn_prev_d  = csn_s;
      sclk_rise_d = sclk_s & ~sclk_prev_q;
      cs_fall_d   = ~csn_s & csn_prev_q;
      cs_rise_d   = csn_s & ~csn_prev_q;
      data_d      = data_s;
      csn_d       = csn_s;

      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
      word_done_s = 1'b0;
      word_s      = {shift_q[DATA_W-2:0], data_q};

      case (state_q)
         IDLE: begin
            if (cs_fall_q) begin
               state_d   = SHIFT;
               bit_cnt_d = {CNT_W{1'b0}};
               shift_d   = {DATA_W{1'b0}};
            end else begin
               state_d   = IDLE;
            end
         end
         SHIFT: begin
            // cs_n rising wins over a coincident spi_clock edge; partial bits are dropped.
            if (cs_rise_q) begin
               state_d     = IDLE;
               frame_err_d = (bit_cnt_q != {CNT_W{1'b0}});
               bit_cnt_d   = {CNT_W{1'b0}};
               shift_d     = {DATA_W{1'b0}};
            end else if (sclk_rise_q && !csn_q) begin
               shift_d = word_s;
               if (bit_cnt_q == CNT_LAST) begin
                  word_done_s = 1'b1;
                  bit_cnt_d   = {CNT_W{1'b0}};
               end else begin
                  bit_cnt_d   = bit_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = {CNT_W{1'b0}};
            shift_d   = {DATA_W{1'b0}};
         end
      endcase

      if (word_done_s) begin
         if (!m_valid_q || m_ready) begin
            m_data_d  = word_s;
            m_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end

      busy_d = (state_d == SHIFT);
   end

   // All state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= {CNT_W{1'b0}};
         shift_q     <= {DATA_W{1'b0}};
         m_data_q    <= {DATA_W{1'b0}};
         m_valid_q   <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         sclk_prev_q <= 1'b0;
         csn_prev_q  <= 1'b1;
         sclk_rise_q <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
         data_q      <= 1'b0;
         csn_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         sclk_prev_q <= sclk_prev_d;
         csn_prev_q  <= csn_prev_d;
         sclk_rise_q <= sclk_rise_d;
         cs_fall_q   <= cs_fall_d;
         cs_rise_q   <= cs_rise_d;
         data_q      <= data_d;
         csn_q       <= csn_d;
      end
   end

   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: drives SPI frames with 4-clk phases and
// checks words, handshake, overrun, frame errors and reset behaviour.
module tb_spi_frame_receiver;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_clock = 1'b0;
   logic        spi_data = 1'b0;
   logic        cs_n = 1'b1;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        overrun;
   logic        frame_err;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   int          acc_cnt = 0;
   int          vcyc    = 0;
   int          ovr_cnt = 0;
   int          fe_cnt  = 0;
   int          busy_cnt = 0;
   logic [15:0] last_acc = 16'h0000;

   always #5 clk = ~clk;

   spi_frame_receiver #(.DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .spi_clock(spi_clock), .spi_data(spi_data), .cs_n(cs_n),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .overrun(overrun), .frame_err(frame_err), .busy(busy)
   );

   // Observe outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready) begin
            acc_cnt  = acc_cnt + 1;
            last_acc = m_data;
         end
         if (m_valid)   vcyc     = vcyc + 1;
         if (overrun)   ovr_cnt  = ovr_cnt + 1;
         if (frame_err) fe_cnt   = fe_cnt + 1;
         if (busy)      busy_cnt = busy_cnt + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_counts();
      acc_cnt = 0; vcyc = 0; ovr_cnt = 0; fe_cnt = 0; busy_cnt = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // n bits MSB first; optionally pulse m_ready so acceptance lands on the last word's load edge
   task automatic send_bits(input logic [15:0] w, input int n, input bit pulse_last);
      for (int i = 15; i > 15 - n; i--) begin
         spi_data = w[i];
         tick(4);
         spi_clock = 1'b1;
         for (int k = 0; k < 4; k++) begin
            tick(1);
            if (pulse_last && (i == 16 - n) && (k == 2)) m_ready = 1'b1;
            if (pulse_last && (i == 16 - n) && (k == 3)) m_ready = 1'b0;
         end
         spi_clock = 1'b0;
      end
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      tick(6);
   endtask

   task automatic cs_high();
      tick(4);
      cs_n = 1'b1;
      tick(8);
   endtask

   task automatic ready_pulse();
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
   endtask

   initial begin
      #2;
      check_eq("reset_m_data", {16'h0, m_data}, 32'h0);
      check_eq("reset_flags", {28'h0, m_valid, overrun, frame_err, busy}, 32'h0);
      tick(3);
      rst_n = 1'b1;
      tick(4);

      // single word, ready held high
      clr_counts();
      m_ready = 1'b1;
      cs_low();
      send_bits(16'hA55A, 16, 1'b0);
      cs_high();
      check_eq("w1_accepts", acc_cnt, 32'd1);
      check_eq("w1_data", {16'h0, last_acc}, 32'h0000A55A);
      check_eq("w1_valid_cycles", vcyc, 32'd1);
      check_eq("w1_flags", ovr_cnt + fe_cnt, 32'd0);
      m_ready = 1'b0;

      // two words, output stalled -> overrun on second
      clr_counts();
      cs_low();
      send_bits(16'h1234, 16, 1'b0);
      send_bits(16'hBEEF, 16, 1'b0);
      cs_high();
      check_eq("ovr_valid_held", {31'h0, m_valid}, 32'd1);
      check_eq("ovr_data_kept", {16'h0, m_data}, 32'h00001234);
      check_eq("ovr_pulses", ovr_cnt, 32'd1);
      ready_pulse();
      check_eq("ovr_drain_valid", {31'h0, m_valid}, 32'd0);
      check_eq("ovr_drain_data", {16'h0, last_acc}, 32'h00001234);

      // acceptance coincides with completion of the next word
      clr_counts();
      cs_low();
      send_bits(16'h1111, 16, 1'b0);
      send_bits(16'h2222, 16, 1'b1);
      cs_high();
      check_eq("coin_accept_first", {16'h0, last_acc}, 32'h00001111);
      check_eq("coin_valid_stays", {31'h0, m_valid}, 32'd1);
      check_eq("coin_data_new", {16'h0, m_data}, 32'h00002222);
      check_eq("coin_no_overrun", ovr_cnt, 32'd0);
      ready_pulse();
      check_eq("coin_drain", {16'h0, last_acc}, 32'h00002222);

      // short frame then a good one
      clr_counts();
      cs_low();
      send_bits(16'hFF80, 9, 1'b0);
      cs_high();
      check_eq("short_fe_pulses", fe_cnt, 32'd1);
      check_eq("short_no_valid", vcyc, 32'd0);
      m_ready = 1'b1;
      cs_low();
      send_bits(16'h00FF, 16, 1'b0);
      cs_high();
      check_eq("after_short_data", {16'h0, last_acc}, 32'h000000FF);
      check_eq("after_short_fe", fe_cnt, 32'd1);

      // spi_clock activity without chip select
      clr_counts();
      send_bits(16'h5AA5, 16, 1'b0);
      tick(8);
      check_eq("nocs_no_valid", vcyc, 32'd0);
      check_eq("nocs_not_busy", busy_cnt, 32'd0);
      cs_low();
      send_bits(16'hC3C3, 16, 1'b0);
      cs_high();
      check_eq("nocs_then_data", {16'h0, last_acc}, 32'h0000C3C3);
      check_eq("nocs_then_accepts", acc_cnt, 32'd1);

      // reset mid-frame with a word pending, cs_n held low across release
      m_ready = 1'b0;
      clr_counts();
      cs_low();
      send_bits(16'h0F0F, 16, 1'b0);
      send_bits(16'hFFFF, 5, 1'b0);
      check_eq("pre_rst_valid", {30'h0, m_valid, busy}, 32'd3);
      rst_n = 1'b0;
      #2;
      check_eq("rst_m_data", {16'h0, m_data}, 32'h0);
      check_eq("rst_flags", {28'h0, m_valid, overrun, frame_err, busy}, 32'h0);
      tick(3);
      rst_n = 1'b1;
      tick(6);
      check_eq("rst_release_busy", {31'h0, busy}, 32'd1);
      clr_counts();
      m_ready = 1'b1;
      send_bits(16'h8001, 16, 1'b0);
      cs_high();
      check_eq("post_rst_data", {16'h0, last_acc}, 32'h00008001);
      check_eq("post_rst_fe", fe_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
